// File: rtl/y86_data_mem_if.sv
// y86_data_mem_if: request/response bus between the Y86-64 memory stage
// (master) and the data-memory responder (slave).
//   req_valid / req_ready : request handshake, accepted when both are high
//   req_write             : 1 = store, 0 = load
//   req_addr              : 64-bit byte address
//   req_wdata             : 64-bit store data
//   rsp_valid / rsp_ready : response handshake, consumed when both are high
//   rsp_rdata             : load data (0 for stores and errors)
//   rsp_stat              : 2'b00 AOK, 2'b10 ADR
interface y86_data_mem_if;
  logic        req_valid;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_stat;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_stat
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_stat
  );
endinterface

// File: rtl/y86_data_mem.sv
// y86_data_mem: byte-addressed, little-endian 64-bit data memory for the
// Y86-64 memory stage. One outstanding access at a time, with WAIT_CYCLES
// extra cycles of latency for in-range addresses. Out-of-range accesses
// answer ADR after a single cycle and leave storage untouched.
// Ports:
//   clk    : clock, all state changes on the rising edge
//   rst_n  : synchronous active-low reset (storage is not cleared)
//   bus    : y86_data_mem_if slave side (request + response handshakes)
//
// state | meaning
// IDLE  | ready for a request (req_ready = 1)
// WAIT  | request latched, wait-state down-counter running
// RESP  | response held on the bus until rsp_ready
module y86_data_mem #(
  parameter int unsigned MEM_BYTES   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  y86_data_mem_if.slave bus
);

  localparam int unsigned AW        = $clog2(MEM_BYTES);
  localparam logic [63:0] ADDR_MAX  = 64'(MEM_BYTES - 8);
  localparam logic [7:0]  WAIT_INIT = 8'(WAIT_CYCLES);
  localparam logic [1:0]  STAT_AOK  = 2'b00;
  localparam logic [1:0]  STAT_ADR  = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, next_state;
  logic            accept, fire;
  logic            req_ready, rsp_valid;

  logic            write_q;
  logic            err_q;
  logic [AW-1:0]   addr_q;
  logic [63:0]     wdata_q;
  logic [7:0]      cnt;

  logic [63:0]     rdata_q;
  logic [1:0]      stat_q;
  logic [63:0]     rd_word;
  logic            addr_err;

  logic [7:0]      mem [MEM_BYTES];

  // Full 64-bit unsigned compare so addresses that would wrap past the top
  // of the 64-bit space are rejected as well.
  assign addr_err = (bus.req_addr > ADDR_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    fire       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          accept     = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 8'd0) begin
          fire       = 1'b1;
          next_state = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latch and wait-state down-counter. Errors skip the wait states.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= 8'd0;
    end else if (accept) begin
      write_q <= bus.req_write;
      err_q   <= addr_err;
      addr_q  <= bus.req_addr[AW-1:0];
      wdata_q <= bus.req_wdata;
      cnt     <= addr_err ? 8'd0 : WAIT_INIT;
    end else if (state == WAIT && cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  // Only in-range addresses reach here with a real access, so a+7 never
  // leaves the array; the AW-bit sum is therefore exact.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 8; i++) begin
      rd_word[8*i +: 8] = mem[addr_q + AW'(i)];
    end
  end

  // Storage commit happens on the RESP-entry edge; a reset on that edge
  // drops the pending write.
  always_ff @(posedge clk) begin
    if (rst_n && fire && write_q && !err_q) begin
      for (int i = 0; i < 8; i++) begin
        mem[addr_q + AW'(i)] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
      stat_q  <= STAT_AOK;
    end else if (fire) begin
      stat_q  <= err_q ? STAT_ADR : STAT_AOK;
      rdata_q <= (err_q || write_q) ? 64'd0 : rd_word;
    end else if (state == RESP && bus.rsp_ready) begin
      rdata_q <= '0;
      stat_q  <= STAT_AOK;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_stat  = stat_q;

endmodule
